// File: rtl/fetch_queue.sv
// Instruction fetch front end: holds the fetch PC, issues in-order word requests, buffers returned words for the decoder.
// Latency: a response enqueued in cycle N is presented on out* in cycle N+1 (no bypass); 1 instr/cycle sustained with 1-cycle memory.
// Backpressure: requests are credit-limited so buffered + in-flight + stale never exceeds DEPTH; outReady low stalls fetch once credit is used up.
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   imemReqValid/Ready/Addr               word request toward instruction memory (addr[1:0] always 0)
//   imemRespValid/Data/Err                in-order response, Err marks an access fault
//   redirectValid/redirectPc              flush everything and restart fetching at redirectPc
//   outValid/outReady/outEnc/outPc/outFetchErr   FIFO head toward the decoder (outEnc is an Instr::enc_t word)
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        imemRespErr,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outEnc,
    output logic [31:0] outPc,
    output logic        outFetchErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]      pc;

    // Data FIFO toward the decoder.
    logic [31:0]      q_enc [DEPTH];
    logic [31:0]      q_pc  [DEPTH];
    logic [DEPTH-1:0] q_err;
    logic [AW-1:0]    q_head;
    logic [AW-1:0]    q_tail;
    logic [CW-1:0]    count;

    // PCs of accepted requests, popped in order as responses return.
    logic [31:0]      f_pc [DEPTH];
    logic [AW-1:0]    f_head;
    logic [AW-1:0]    f_tail;
    logic [CW-1:0]    inflight;

    // Responses still owed from requests issued before the last redirect.
    logic [CW-1:0]    stale;
    logic             halted;

    logic [CW+1:0]    credit_used;
    logic             req_fire;
    logic             resp_live;
    logic             resp_stale;
    logic             resp_any;
    logic             deq;

    assign credit_used  = {2'b00, count} + {2'b00, inflight} + {2'b00, stale};
    assign imemReqValid = !rst && !halted && !redirectValid && (credit_used < (CW+2)'(DEPTH));
    assign imemReqAddr  = pc;
    assign req_fire     = imemReqValid && imemReqReady;

    // A response with nothing owed is ignored rather than corrupting the counters.
    assign resp_stale   = imemRespValid && (stale != '0);
    assign resp_live    = imemRespValid && (stale == '0) && (inflight != '0);
    assign resp_any     = resp_stale || resp_live;

    assign outValid     = !rst && (count != '0);
    assign outPc        = outValid ? q_pc[q_head] : 32'h0;
    assign outEnc       = (outValid && !q_err[q_head]) ? q_enc[q_head] : 32'h0;
    assign outFetchErr  = outValid && q_err[q_head];
    assign deq          = outValid && outReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            q_head   <= '0;
            q_tail   <= '0;
            count    <= '0;
            f_head   <= '0;
            f_tail   <= '0;
            inflight <= '0;
            stale    <= '0;
            halted   <= 1'b0;
        end else if (redirectValid) begin
            // Everything outstanding becomes stale; a response this cycle pays one of them off.
            pc       <= {redirectPc[31:2], 2'b00};
            q_head   <= '0;
            q_tail   <= '0;
            count    <= '0;
            f_head   <= '0;
            f_tail   <= '0;
            inflight <= '0;
            stale    <= stale + inflight - CW'(resp_any);
            halted   <= 1'b0;
        end else begin
            if (req_fire) begin
                pc     <= pc + 32'd4;
                f_tail <= f_tail + 1'b1;
            end
            if (resp_stale) begin
                stale <= stale - 1'b1;
            end
            if (resp_live) begin
                q_tail <= q_tail + 1'b1;
                f_head <= f_head + 1'b1;
                if (imemRespErr) begin
                    halted <= 1'b1;
                end
            end
            if (deq) begin
                q_head <= q_head + 1'b1;
            end
            inflight <= inflight + CW'(req_fire) - CW'(resp_live);
            count    <= count + CW'(resp_live) - CW'(deq);
        end
    end

    // Storage needs no reset: the pointers and counters decide what is valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            f_pc[f_tail] <= pc;
        end
        if (resp_live) begin
            q_enc[q_tail] <= imemRespData;
            q_pc[q_tail]  <= f_pc[f_head];
            q_err[q_tail] <= imemRespErr;
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the decoder. It holds the fetch PC and issues in-order word requests to instruction memory, buffering returned instruction words with their PCs in a small FIFO. The FIFO head drives the decoder input as a 32-bit `Instr::enc_t` together with its PC over a valid/ready handshake. Branch and exception redirects flush all buffered and in-flight fetches and restart at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2. Also caps total requests in flight.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `imemReqValid`  out  1  request valid.
- `imemReqReady`  in  1  memory accepts the request.
- `imemReqAddr`  out  32  word-aligned fetch address; bits [1:0] are always 0.
- `imemRespValid`  in  1  response valid; responses arrive in request order, at least 1 cycle after acceptance.
- `imemRespData`  in  32  instruction word.
- `imemRespErr`  in  1  access fault for this response.
- `redirectValid`  in  1  flush and restart.
- `redirectPc`  in  32  restart PC; bits [1:0] are ignored and treated as 0.
- `outValid`  out  1  FIFO head valid toward the decoder.
- `outReady`  in  1  decoder consumes the head.
- `outEnc`  out  32  `Instr::enc_t` of the head entry; all zeros when `outFetchErr` is set.
- `outPc`  out  32  PC of the head entry.
- `outFetchErr`  out  1  head entry carries a fetch fault.

## Operation
- State:
  - `pc`
  - FIFO of {enc, pc, err} with head/tail pointers and `count`
  - in-flight PC FIFO of depth `DEPTH`
  - `inflight`: accepted requests not yet answered
  - `stale`: responses still owed from before a redirect
  - `halted` flag
- Credit rule: `imemReqValid = !rst && !halted && !redirectValid && (count + inflight + stale < DEPTH)`. The data FIFO can therefore never overflow.
- `imemReqAddr = pc`.
- On a request handshake:
  - push `pc` into the in-flight PC FIFO;
  - `pc <= pc + 4` (wraps mod 2^32);
  - `inflight++`.
- On a response while `stale > 0`: discard it and decrement `stale`.
- On a response while `stale == 0`:
  - pop the in-flight PC and decrement `inflight`;
  - enqueue {data, pc, err};
  - if `err`, set `halted`. No further requests are issued until a redirect.
- Dequeue when `outValid && outReady`.
- Enqueue and dequeue in the same cycle are both performed; `count` is unchanged.
- Redirect, which has priority over everything else:
  - FIFO emptied and `count <= 0`;
  - `pc <= {redirectPc[31:2], 2'b00}`;
  - `halted <= 0`;
  - `stale <= stale + inflight - (resp this cycle ? 1 : 0)`;
  - `inflight <= 0`;
  - in-flight PC FIFO cleared;
  - a response arriving in the redirect cycle is discarded;
  - a dequeue in the redirect cycle still counts as consumed by the decoder, but the FIFO is empty afterward.
- `imemReqAddr` and `imemReqValid` are held stable while `imemReqReady` is low, unless a redirect or reset occurs.

## Timing
- Reset values:
  - `pc = RESET_PC`;
  - `count`, `inflight`, `stale` = 0;
  - `halted = 0`;
  - `imemReqValid = 0` and `outValid = 0` during the reset cycle;
  - `outEnc`, `outPc`, `outFetchErr` = 0 while `outValid = 0`.
- First request is presented in the first cycle after `rst` deasserts.
- Reset mid-operation discards everything, including outstanding memory responses. The memory is reset in the same cycle.
- A response enqueued in cycle N is visible on `out*` in cycle N+1. There is no bypass path.
- With a memory of 1-cycle latency and `outReady = 1`, throughput is 1 instruction per cycle sustained.
- Redirect in cycle N:
  - `imemReqValid = 0` in cycle N;
  - first request at the new PC in cycle N+1, if credit allows;
  - `outValid = 0` in cycle N+1.
- Wrap-around: both FIFO pointers wrap mod `DEPTH`, and the PC wraps 32'hFFFF_FFFC -> 0.

## Test plan
- **Sequential fetch:** reset, 1-cycle memory returning `addr ^ 32'hA5A5_0000`, `outReady = 1` -> requests 0x0, 0x4, 0x8 … on consecutive cycles; `out*` shows matching enc/pc pairs from cycle 2 onward, with no gaps.
- **Backpressure:** `outReady = 0`, DEPTH = 4 -> exactly 4 requests accepted, then `imemReqValid = 0`. Raising `outReady` drains 0x0..0xC in order and fetching resumes at 0x10.
- **Request stall:** hold `imemReqReady = 0` for 3 cycles -> `imemReqAddr` stays constant and `pc` does not advance.
- **Redirect:** 2-cycle memory with 2 requests outstanding (0x8, 0xC), then redirect to 0x103 -> both responses discarded; next request is 0x100; first `outPc` after redirect is 0x100.
- **Fetch fault:** respond to 0x4 with `imemRespErr = 1` -> the head at 0x4 has `outFetchErr = 1` and `outEnc = 0`; no requests are issued until a redirect to 0x40 restarts fetching.
- **Reset mid-operation:** assert `rst` with a full FIFO and 1 request in flight -> the next cycle has `outValid = 0`, and the first request after reset is to `RESET_PC`.
